// File: rtl/bus_rr_arbiter_if.sv
// Host and device bus bundle for the round-robin arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding hosts and devices.
interface bus_rr_arbiter_if #(
    parameter int NrHosts      = 2,
    parameter int NrDevices    = 4,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
);
    logic [NrHosts-1:0]                     host_req_i;
    logic [NrHosts-1:0]                     host_gnt_o;
    logic [NrHosts-1:0][AddressWidth-1:0]   host_addr_i;
    logic [NrHosts-1:0]                     host_we_i;
    logic [NrHosts-1:0][DataWidth/8-1:0]    host_be_i;
    logic [NrHosts-1:0][DataWidth-1:0]      host_wdata_i;
    logic [NrHosts-1:0]                     host_rvalid_o;
    logic [NrHosts-1:0][DataWidth-1:0]      host_rdata_o;
    logic [NrHosts-1:0]                     host_err_o;
    logic [NrDevices-1:0]                   device_req_o;
    logic [NrDevices-1:0][AddressWidth-1:0] device_addr_o;
    logic [NrDevices-1:0]                   device_we_o;
    logic [NrDevices-1:0][DataWidth/8-1:0]  device_be_o;
    logic [NrDevices-1:0][DataWidth-1:0]    device_wdata_o;
    logic [NrDevices-1:0]                   device_rvalid_i;
    logic [NrDevices-1:0][DataWidth-1:0]    device_rdata_i;
    logic [NrDevices-1:0]                   device_err_i;
    logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_base;
    logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_mask;

    modport slave (
        input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        output device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
        input  device_rvalid_i, device_rdata_i, device_err_i,
        input  cfg_device_addr_base, cfg_device_addr_mask
    );

    modport master (
        output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        input  device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
        output device_rvalid_i, device_rdata_i, device_err_i,
        output cfg_device_addr_base, cfg_device_addr_mask
    );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin multi-host interconnect: one outstanding transaction, base/mask address decode,
// error responses for unmapped addresses and for devices that stay silent past the timeout.
module bus_rr_arbiter #(
    parameter int NrHosts       = 2,
    parameter int NrDevices     = 4,
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    bus_rr_arbiter_if.slave bus
);
    localparam int HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
    localparam int TimerW   = $clog2(TimeoutCycles) + 1;
    // The incremented count reaching TimeoutCycles-1 expires the slot, so the error
    // response lands exactly TimeoutCycles cycles after the grant.
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TimeoutCycles - 2);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e                             r_state;
    logic [HostIdxW-1:0]                r_ptr;
    logic [HostIdxW-1:0]                r_host_q;
    logic [DevIdxW-1:0]                 r_dev_q;
    logic                               r_mapped;
    logic [TimerW-1:0]                  r_timer;
    logic [NrHosts-1:0]                 r_rvalid;
    logic [NrHosts-1:0]                 r_err;
    logic [NrHosts-1:0][DataWidth-1:0]  r_rdata;

    logic                    w_dev_rvalid;
    logic                    w_timeout;
    logic                    w_complete;
    logic                    w_gnt_allowed;
    logic                    w_found;
    logic                    w_take;
    logic [HostIdxW-1:0]     w_cand;
    logic [HostIdxW-1:0]     w_gnt_idx;
    logic                    w_grant;
    logic [AddressWidth-1:0] w_addr;
    logic                    w_hit;
    logic                    w_mapped;
    logic [DevIdxW-1:0]      w_dev_idx;

    assign w_dev_rvalid  = bus.device_rvalid_i[r_dev_q];
    assign w_timeout     = (r_timer == TimerLast);
    assign w_complete    = (r_state == ST_WAIT) && (!r_mapped || w_dev_rvalid || w_timeout);
    assign w_gnt_allowed = rst_ni && ((r_state == ST_IDLE) || w_complete);
    assign w_grant       = w_gnt_allowed && w_found;
    assign w_addr        = bus.host_addr_i[w_gnt_idx];

    // Round-robin search starting one past the last granted host.
    always_comb begin
        w_found   = 1'b0;
        w_take    = 1'b0;
        w_cand    = '0;
        w_gnt_idx = '0;
        for (int i = 1; i <= NrHosts; i++) begin
            w_cand    = HostIdxW'((int'(r_ptr) + i) % NrHosts);
            w_take    = !w_found && bus.host_req_i[w_cand];
            w_gnt_idx = w_take ? w_cand : w_gnt_idx;
            w_found   = w_found || w_take;
        end
    end

    // Address decode of the granted host; walking downwards lets the lowest match win.
    always_comb begin
        w_hit     = 1'b0;
        w_mapped  = 1'b0;
        w_dev_idx = '0;
        for (int d = NrDevices - 1; d >= 0; d--) begin
            w_hit     = ((w_addr & bus.cfg_device_addr_mask[d]) ==
                         (bus.cfg_device_addr_base[d] & bus.cfg_device_addr_mask[d]));
            w_dev_idx = w_hit ? DevIdxW'(d) : w_dev_idx;
            w_mapped  = w_mapped || w_hit;
        end
    end

    // Grant and device request fan-out; every device sees the granted host's fields.
    always_comb begin
        bus.host_gnt_o     = '0;
        bus.device_req_o   = '0;
        bus.device_addr_o  = '0;
        bus.device_we_o    = '0;
        bus.device_be_o    = '0;
        bus.device_wdata_o = '0;
        for (int h = 0; h < NrHosts; h++) begin
            bus.host_gnt_o[h] = w_grant && (w_gnt_idx == HostIdxW'(h));
        end
        for (int d = 0; d < NrDevices; d++) begin
            bus.device_req_o[d]   = w_grant && w_mapped && (w_dev_idx == DevIdxW'(d));
            bus.device_addr_o[d]  = w_addr;
            bus.device_we_o[d]    = bus.host_we_i[w_gnt_idx];
            bus.device_be_o[d]    = bus.host_be_i[w_gnt_idx];
            bus.device_wdata_o[d] = bus.host_wdata_i[w_gnt_idx];
        end
    end

    // Transaction FSM with registered host responses; a grant in the completion cycle overrides.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_ptr    <= HostIdxW'(NrHosts - 1);
            r_host_q <= '0;
            r_dev_q  <= '0;
            r_mapped <= 1'b0;
            r_timer  <= '0;
            r_rvalid <= '0;
            r_err    <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= '0;
            r_err    <= '0;
            r_rdata  <= '0;
            case (r_state)
                ST_WAIT: begin
                    if (w_complete) begin
                        if (r_mapped) begin
                            r_rvalid[r_host_q] <= 1'b1;
                            r_err[r_host_q]    <= w_dev_rvalid ? bus.device_err_i[r_dev_q] : 1'b1;
                            r_rdata[r_host_q]  <= w_dev_rvalid ? bus.device_rdata_i[r_dev_q] : '0;
                        end
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TimerW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_grant) begin
                r_ptr    <= w_gnt_idx;
                r_host_q <= w_gnt_idx;
                r_dev_q  <= w_dev_idx;
                r_mapped <= w_mapped;
                r_timer  <= '0;
                r_state  <= ST_WAIT;
                if (!w_mapped) begin
                    r_rvalid[w_gnt_idx] <= 1'b1;
                    r_err[w_gnt_idx]    <= 1'b1;
                end
            end
        end
    end

    assign bus.host_rvalid_o = r_rvalid;
    assign bus.host_err_o    = r_err;
    assign bus.host_rdata_o  = r_rdata;
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed self-checking bench for bus_rr_arbiter (2 hosts, 4 devices, timeout 16).
module tb_bus_rr_arbiter;
    logic clk;
    logic rst_ni;
    int   tests_run;
    int   tests_failed;

    bus_rr_arbiter_if #(.NrHosts(2), .NrDevices(4), .DataWidth(32), .AddressWidth(32)) bus ();

    bus_rr_arbiter #(
        .NrHosts(2), .NrDevices(4), .DataWidth(32), .AddressWidth(32), .TimeoutCycles(16)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.host_req_i      = 2'b00;
        bus.host_we_i       = 2'b00;
        bus.host_be_i       = '0;
        bus.host_wdata_i    = '0;
        bus.host_addr_i     = '0;
        bus.device_rvalid_i = 4'b0000;
        bus.device_err_i    = 4'b0000;
        bus.device_rdata_i  = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_ni = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_ni = 1'b0;
        bus.host_addr_i[0] = 32'h0010_0000;
        bus.host_addr_i[1] = 32'h0020_0000;
        bus.host_req_i     = 2'b11;
        next_cycle();
        tests_run++;
        if (bus.host_gnt_o !== 2'b00) begin tests_failed++; $display("FAIL reset_gnt: got %b expected 00", bus.host_gnt_o); end
        tests_run++;
        if (bus.device_req_o !== 4'b0000) begin tests_failed++; $display("FAIL reset_dreq: got %b expected 0000", bus.device_req_o); end
        next_cycle();
        tests_run++;
        if ({bus.host_rvalid_o, bus.host_err_o} !== 4'b0000) begin tests_failed++; $display("FAIL reset_rsp: got %b expected 0000", {bus.host_rvalid_o, bus.host_err_o}); end
        tests_run++;
        if (bus.host_rdata_o !== 64'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h expected 0", bus.host_rdata_o); end
        rst_ni = 1'b1;
        #1;
        tests_run++;
        if (bus.host_gnt_o !== 2'b01) begin tests_failed++; $display("FAIL reset_first_gnt: got %b expected 01", bus.host_gnt_o); end
    endtask

    task automatic test_single_read();
        apply_reset();
        bus.host_addr_i[0] = 32'h0010_0004;
        bus.host_req_i     = 2'b01;
        #1;
        tests_run++;
        if (bus.host_gnt_o !== 2'b01) begin tests_failed++; $display("FAIL read_gnt: got %b expected 01", bus.host_gnt_o); end
        tests_run++;
        if (bus.device_req_o !== 4'b0001) begin tests_failed++; $display("FAIL read_dreq: got %b expected 0001", bus.device_req_o); end
        tests_run++;
        if (bus.device_addr_o[0] !== 32'h0010_0004) begin tests_failed++; $display("FAIL read_daddr: got %h expected 00100004", bus.device_addr_o[0]); end
        next_cycle();
        bus.host_req_i        = 2'b00;
        bus.device_rvalid_i   = 4'b0001;
        bus.device_rdata_i[0] = 32'hDEAD_BEEF;
        #1;
        tests_run++;
        if (bus.host_rvalid_o !== 2'b00) begin tests_failed++; $display("FAIL read_early_rvalid: got %b expected 00", bus.host_rvalid_o); end
        next_cycle();
        bus.device_rvalid_i = 4'b0000;
        #1;
        tests_run++;
        if (bus.host_rvalid_o !== 2'b01) begin tests_failed++; $display("FAIL read_rvalid: got %b expected 01", bus.host_rvalid_o); end
        tests_run++;
        if (bus.host_rdata_o[0] !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL read_rdata: got %h expected deadbeef", bus.host_rdata_o[0]); end
        tests_run++;
        if (bus.host_err_o !== 2'b00) begin tests_failed++; $display("FAIL read_err: got %b expected 00", bus.host_err_o); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  prev_req;
        logic [1:0]  exp_hot;
        logic [31:0] exp_data;
        apply_reset();
        prev_req           = 4'b0000;
        bus.host_addr_i[0] = 32'h0010_0010;
        bus.host_addr_i[1] = 32'h0020_0020;
        bus.host_req_i     = 2'b11;
        for (int c = 0; c < 8; c++) begin
            bus.device_rvalid_i   = prev_req;
            bus.device_rdata_i[0] = 32'h1000_0000 + 32'(c);
            bus.device_rdata_i[1] = 32'h2000_0000 + 32'(c);
            #1;
            exp_hot = (c % 2 == 0) ? 2'b01 : 2'b10;
            tests_run++;
            if (bus.host_gnt_o !== exp_hot) begin tests_failed++; $display("FAIL b2b_gnt c=%0d: got %b expected %b", c, bus.host_gnt_o, exp_hot); end
            tests_run++;
            if (bus.device_req_o !== {2'b00, exp_hot}) begin tests_failed++; $display("FAIL b2b_dreq c=%0d: got %b expected %b", c, bus.device_req_o, {2'b00, exp_hot}); end
            if (c >= 2) begin
                exp_data = ((c % 2 == 0) ? 32'h1000_0000 : 32'h2000_0000) + 32'(c - 1);
                tests_run++;
                if (bus.host_rvalid_o !== exp_hot) begin tests_failed++; $display("FAIL b2b_rvalid c=%0d: got %b expected %b", c, bus.host_rvalid_o, exp_hot); end
                tests_run++;
                if (bus.host_rdata_o[c % 2] !== exp_data) begin tests_failed++; $display("FAIL b2b_rdata c=%0d: got %h expected %h", c, bus.host_rdata_o[c % 2], exp_data); end
            end else begin
                tests_run++;
                if (bus.host_rvalid_o !== 2'b00) begin tests_failed++; $display("FAIL b2b_rvalid c=%0d: got %b expected 00", c, bus.host_rvalid_o); end
            end
            prev_req = bus.device_req_o;
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_unmapped();
        apply_reset();
        bus.device_rdata_i     = {4{32'h5555_AAAA}};
        bus.host_addr_i[1]     = 32'h0005_0000;
        bus.host_we_i          = 2'b10;
        bus.host_be_i[1]       = 4'hF;
        bus.host_wdata_i[1]    = 32'h1122_3344;
        bus.host_req_i         = 2'b10;
        #1;
        tests_run++;
        if (bus.host_gnt_o !== 2'b10) begin tests_failed++; $display("FAIL unmap_gnt: got %b expected 10", bus.host_gnt_o); end
        tests_run++;
        if (bus.device_req_o !== 4'b0000) begin tests_failed++; $display("FAIL unmap_dreq: got %b expected 0000", bus.device_req_o); end
        next_cycle();
        bus.host_req_i = 2'b00;
        #1;
        tests_run++;
        if ({bus.host_rvalid_o, bus.host_err_o} !== 4'b1010) begin tests_failed++; $display("FAIL unmap_rsp: got %b expected 1010", {bus.host_rvalid_o, bus.host_err_o}); end
        tests_run++;
        if (bus.host_rdata_o[1] !== 32'h0) begin tests_failed++; $display("FAIL unmap_rdata: got %h expected 0", bus.host_rdata_o[1]); end
        next_cycle();
        tests_run++;
        if (bus.host_rvalid_o !== 2'b00) begin tests_failed++; $display("FAIL unmap_pulse: got %b expected 00", bus.host_rvalid_o); end
        clear_inputs();
    endtask

    task automatic test_timeout();
        apply_reset();
        bus.host_addr_i[0] = 32'h0030_0008;
        bus.host_addr_i[1] = 32'h0020_0000;
        bus.host_req_i     = 2'b01;
        #1;
        tests_run++;
        if (bus.device_req_o !== 4'b0100) begin tests_failed++; $display("FAIL tmo_dreq: got %b expected 0100", bus.device_req_o); end
        next_cycle();
        bus.host_req_i = 2'b10;
        for (int c = 1; c < 15; c++) begin
            #1;
            tests_run++;
            if ({bus.host_gnt_o, bus.host_rvalid_o} !== 4'b0000) begin tests_failed++; $display("FAIL tmo_quiet c=%0d: got %b expected 0000", c, {bus.host_gnt_o, bus.host_rvalid_o}); end
            next_cycle();
        end
        #1;
        tests_run++;
        if (bus.host_gnt_o !== 2'b10) begin tests_failed++; $display("FAIL tmo_regrant: got %b expected 10", bus.host_gnt_o); end
        next_cycle();
        bus.host_req_i        = 2'b00;
        bus.device_rvalid_i   = 4'b0110;
        bus.device_rdata_i[1] = 32'hCAFE_0001;
        bus.device_rdata_i[2] = 32'hBAD0_0002;
        bus.device_err_i      = 4'b0100;
        #1;
        tests_run++;
        if ({bus.host_rvalid_o, bus.host_err_o} !== 4'b0101) begin tests_failed++; $display("FAIL tmo_rsp: got %b expected 0101", {bus.host_rvalid_o, bus.host_err_o}); end
        tests_run++;
        if (bus.host_rdata_o[0] !== 32'h0) begin tests_failed++; $display("FAIL tmo_rdata: got %h expected 0", bus.host_rdata_o[0]); end
        next_cycle();
        bus.device_rvalid_i = 4'b0100;
        #1;
        tests_run++;
        if ({bus.host_rvalid_o, bus.host_err_o} !== 4'b1000) begin tests_failed++; $display("FAIL tmo_next_rsp: got %b expected 1000", {bus.host_rvalid_o, bus.host_err_o}); end
        tests_run++;
        if (bus.host_rdata_o[1] !== 32'hCAFE_0001) begin tests_failed++; $display("FAIL tmo_next_rdata: got %h expected cafe0001", bus.host_rdata_o[1]); end
        next_cycle();
        bus.device_rvalid_i = 4'b0000;
        #1;
        tests_run++;
        if (bus.host_rvalid_o !== 2'b00) begin tests_failed++; $display("FAIL tmo_late_drop: got %b expected 00", bus.host_rvalid_o); end
        clear_inputs();
    endtask

    task automatic test_device_error();
        apply_reset();
        bus.host_addr_i[1] = 32'h0020_0004;
        bus.host_req_i     = 2'b10;
        #1;
        tests_run++;
        if (bus.device_req_o !== 4'b0010) begin tests_failed++; $display("FAIL derr_dreq: got %b expected 0010", bus.device_req_o); end
        next_cycle();
        bus.host_req_i        = 2'b00;
        bus.device_rvalid_i   = 4'b0010;
        bus.device_err_i      = 4'b0010;
        bus.device_rdata_i[1] = 32'h1234_5678;
        next_cycle();
        bus.device_rvalid_i = 4'b0000;
        bus.device_err_i    = 4'b0000;
        #1;
        tests_run++;
        if ({bus.host_rvalid_o, bus.host_err_o} !== 4'b1010) begin tests_failed++; $display("FAIL derr_rsp: got %b expected 1010", {bus.host_rvalid_o, bus.host_err_o}); end
        tests_run++;
        if (bus.host_rdata_o[1] !== 32'h1234_5678) begin tests_failed++; $display("FAIL derr_rdata: got %h expected 12345678", bus.host_rdata_o[1]); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.host_addr_i[0] = 32'h0010_0000;
        bus.host_addr_i[1] = 32'h0020_0000;
        bus.host_req_i     = 2'b01;
        #1;
        tests_run++;
        if (bus.host_gnt_o !== 2'b01) begin tests_failed++; $display("FAIL rmid_gnt: got %b expected 01", bus.host_gnt_o); end
        next_cycle();
        rst_ni                = 1'b0;
        bus.host_req_i        = 2'b11;
        bus.device_rvalid_i   = 4'b0001;
        bus.device_rdata_i[0] = 32'h0000_0077;
        #1;
        tests_run++;
        if (bus.host_gnt_o !== 2'b00) begin tests_failed++; $display("FAIL rmid_gnt_in_rst: got %b expected 00", bus.host_gnt_o); end
        next_cycle();
        tests_run++;
        if (bus.host_rvalid_o !== 2'b00) begin tests_failed++; $display("FAIL rmid_rvalid: got %b expected 00", bus.host_rvalid_o); end
        next_cycle();
        rst_ni              = 1'b1;
        bus.device_rvalid_i = 4'b0000;
        #1;
        tests_run++;
        if ({bus.host_gnt_o, bus.host_rvalid_o} !== 4'b0100) begin tests_failed++; $display("FAIL rmid_after: got %b expected 0100", {bus.host_gnt_o, bus.host_rvalid_o}); end
        next_cycle();
        bus.host_req_i = 2'b00;
        #1;
        tests_run++;
        if (bus.host_rvalid_o !== 2'b00) begin tests_failed++; $display("FAIL rmid_no_rsp: got %b expected 00", bus.host_rvalid_o); end
        clear_inputs();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_ni       = 1'b0;
        clear_inputs();
        bus.cfg_device_addr_base[0] = 32'h0010_0000;
        bus.cfg_device_addr_base[1] = 32'h0020_0000;
        bus.cfg_device_addr_base[2] = 32'h0030_0000;
        bus.cfg_device_addr_base[3] = 32'h0040_0000;
        bus.cfg_device_addr_mask    = {4{32'hFFF0_0000}};
        test_reset();
        test_single_read();
        test_back_to_back();
        test_unmapped();
        test_timeout();
        test_device_error();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
